conv1d_stream_array: RTL

- Next-generation streaming 1-D convolution engine with P parallel MAC lanes and a run-time loadable filter instead of a fixed ROM.
- Accepts an LENX-sample frame on a valid/ready input stream and LENF coefficients on a second valid/ready stream.
- Emits SIZE = LENX-LENF+1 saturated results, with optional ReLU, on a valid/ready output stream in index order.
- Sits between the sample source and the downstream consumer, replacing the ROM-filter convolver.

---
 rtl/conv1d_pkg.sv | 30 +++
 rtl/conv1d_lane.sv | 57 +++++
 rtl/conv1d_stream_array.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
package conv1d_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Full-precision accumulator width: LENF products of two WIDTH-bit signed
  // values can never overflow 2*WIDTH + clog2(LENF) + 1 bits.
  function automatic int acc_w(input int width, input int lenf);
    return 2 * width + $clog2(lenf) + 1;
  endfunction

  // Clamp a sign-extended accumulator into the signed range of 'width' bits.
  // The result is returned sign-extended; callers keep the low 'width' bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] acc,
                                               input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/conv1d_lane.sv
// One MAC lane: full-precision accumulator plus a saturating, optionally
// ReLU-clamped result register that is loaded on the final tap.
module conv1d_lane
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    cap,
  input  logic                    mask,
  input  logic                    relu,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] f,
  output logic signed [WIDTH-1:0] y
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   res;
  logic signed [WIDTH-1:0]   y_q, y_d;

  // Next accumulator value and the saturated/ReLU result of the final tap.
  always_comb begin
    prod     = x * f;
    prod_ext = ACC_W'(prod);
    acc_sum  = acc_q + prod_ext;
    res      = WIDTH'(sat_w(64'(acc_sum), WIDTH));
    if (relu && res[WIDTH-1]) res = '0;

    acc_d = acc_q;
    if (clr) acc_d = '0;
    else if (en && !mask) acc_d = acc_sum;

    y_d = y_q;
    if (cap && en && !mask) y_d = res;
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/conv1d_stream_array.sv
// Streaming 1-D convolution: loads a sample frame and a filter over two
// valid/ready streams, computes P outputs per group in LENF cycles, and
// drains them in index order on a valid/ready output stream.
//
// Handshake rule on every stream: a beat transfers on a rising edge where
// valid and ready are both high; a valid source holds its data unchanged
// until that edge, and ready never depends combinationally on valid.
module conv1d_stream_array
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENX  = 16,
  parameter int LENF  = 4,
  parameter int P     = 2,
  parameter int LOGX  = $clog2(LENX),
  parameter int LOGF  = $clog2(LENF) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic [WIDTH-1:0] s_data_in_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic             f_reload,
  input  logic             relu_en,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int SIZE  = LENX - LENF + 1;
  localparam int ACC_W = acc_w(WIDTH, LENF);
  localparam int XW    = LOGX + 1;
  localparam int LW    = $clog2(P) + 1;

  localparam logic [XW-1:0]   LENX_C  = XW'(LENX);
  localparam logic [LOGF-1:0] LENF_C  = LOGF'(LENF);
  localparam logic [LOGF-1:0] KLAST_C = LOGF'(LENF - 1);
  localparam logic [XW-1:0]   P_C     = XW'(P);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_cnt_q, x_cnt_d;
  logic [LOGF-1:0] f_cnt_q, f_cnt_d;
  logic [LOGF-1:0] k_q, k_d;
  logic [XW-1:0]   grp_base_q, grp_base_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            relu_q, relu_d;
  logic            m_valid_q, m_valid_d;

  logic signed [WIDTH-1:0] xbuf_q [LENX];
  logic signed [WIDTH-1:0] xbuf_d [LENX];
  logic signed [WIDTH-1:0] fbuf_q [LENF];
  logic signed [WIDTH-1:0] fbuf_d [LENF];

  logic x_hs, f_hs, y_hs;
  logic load_done, k_last, lane_last, more_groups;
  logic acc_clr, lane_en;
  int   grp_rem, grp_n;

  logic signed [WIDTH-1:0] lane_x [P];
  logic signed [WIDTH-1:0] lane_y [P];
  logic                    lane_mask [P];
  logic signed [WIDTH-1:0] f_tap;

  // Stream readiness, handshakes and group bookkeeping.
  always_comb begin
    s_ready_x   = (state_q == ST_LOAD) && (x_cnt_q < LENX_C);
    s_ready_f   = (state_q == ST_LOAD) && (f_cnt_q < LENF_C) && !f_reload;
    x_hs        = s_valid_x && s_ready_x;
    f_hs        = s_valid_f && s_ready_f;
    y_hs        = (state_q == ST_DRAIN) && m_valid_q && m_ready_y;
    load_done   = (state_q == ST_LOAD) && (x_cnt_q == LENX_C) &&
                  (f_cnt_q == LENF_C) && !f_reload;
    k_last      = (state_q == ST_COMPUTE) && (k_q == KLAST_C);
    grp_rem     = SIZE - int'(grp_base_q);
    grp_n       = (grp_rem > P) ? P : grp_rem;
    lane_last   = (int'(lane_q) == grp_n - 1);
    more_groups = (int'(grp_base_q) + P) < SIZE;
    lane_en     = (state_q == ST_COMPUTE);
  end

  // Controller: LOAD fills buffers, COMPUTE runs LENF taps, DRAIN emits a group.
  always_comb begin
    state_d    = state_q;
    x_cnt_d    = x_cnt_q;
    f_cnt_d    = f_cnt_q;
    k_d        = k_q;
    grp_base_d = grp_base_q;
    lane_d     = lane_q;
    relu_d     = relu_q;
    m_valid_d  = m_valid_q;
    xbuf_d     = xbuf_q;
    fbuf_d     = fbuf_q;
    acc_clr    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (x_hs) begin
          for (int j = 0; j < LENX; j++)
            if (int'(x_cnt_q) == j) xbuf_d[j] = s_data_in_x;
          x_cnt_d = x_cnt_q + XW'(1);
        end
        // A reload wins over a same-cycle coefficient (ready is low then).
        if (f_reload) begin
          f_cnt_d = '0;
        end else if (f_hs) begin
          for (int j = 0; j < LENF; j++)
            if (int'(f_cnt_q) == j) fbuf_d[j] = s_data_in_f;
          f_cnt_d = f_cnt_q + LOGF'(1);
        end
        if (load_done) begin
          state_d = ST_COMPUTE;
          k_d     = '0;
          acc_clr = 1'b1;
          relu_d  = relu_en;
        end
      end
      ST_COMPUTE: begin
        if (k_last) begin
          state_d   = ST_DRAIN;
          k_d       = '0;
          lane_d    = '0;
          m_valid_d = 1'b1;
        end else begin
          k_d = k_q + LOGF'(1);
        end
      end
      ST_DRAIN: begin
        if (y_hs) begin
          lane_d = lane_q + LW'(1);
          if (lane_last) begin
            m_valid_d = 1'b0;
            lane_d    = '0;
            if (more_groups) begin
              grp_base_d = grp_base_q + P_C;
              state_d    = ST_COMPUTE;
              k_d        = '0;
              acc_clr    = 1'b1;
              relu_d     = relu_en;
            end else begin
              grp_base_d = '0;
              x_cnt_d    = '0;
              state_d    = ST_LOAD;
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control registers; reset also invalidates the stored filter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      x_cnt_q    <= '0;
      f_cnt_q    <= '0;
      k_q        <= '0;
      grp_base_q <= '0;
      lane_q     <= '0;
      relu_q     <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_cnt_q    <= x_cnt_d;
      f_cnt_q    <= f_cnt_d;
      k_q        <= k_d;
      grp_base_q <= grp_base_d;
      lane_q     <= lane_d;
      relu_q     <= relu_d;
      m_valid_q  <= m_valid_d;
    end
  end

  // Sample and coefficient storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    xbuf_q <= xbuf_d;
    fbuf_q <= fbuf_d;
  end

  // Per-lane operand selection and masking of lanes past the last output.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      lane_mask[i] = (int'(grp_base_q) + i) >= SIZE;
      lane_x[i]    = '0;
      for (int j = 0; j < LENX; j++)
        if (int'(grp_base_q) + i + int'(k_q) == j) lane_x[i] = xbuf_q[j];
    end
    f_tap = '0;
    for (int j = 0; j < LENF; j++)
      if (int'(k_q) == j) f_tap = fbuf_q[j];
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    conv1d_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .en    (lane_en),
      .cap   (k_last),
      .mask  (lane_mask[gi]),
      .relu  (relu_q),
      .x     (lane_x[gi]),
      .f     (f_tap),
      .y     (lane_y[gi])
    );
  end

  // Output mux over the registered lane results.
  always_comb begin
    m_data_out_y = '0;
    for (int i = 0; i < P; i++)
      if (int'(lane_q) == i) m_data_out_y = lane_y[i];
  end

  assign m_valid_y = m_valid_q;
  assign busy      = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign dbg_state = state_q;

endmodule
